// File: rtl/mdu_pkg.sv
// Shared definitions for the multiply/divide unit: operation encodings and default latencies.
// The controller and hazard unit import this package as well.
package mdu_pkg;

   // mdop encodings; bit 2 clear marks a multi-cycle arithmetic op, bit 1 selects divide
   localparam logic [2:0] MDOP_MULT  = 3'b000;
   localparam logic [2:0] MDOP_MULTU = 3'b001;
   localparam logic [2:0] MDOP_DIV   = 3'b010;
   localparam logic [2:0] MDOP_DIVU  = 3'b011;
   localparam logic [2:0] MDOP_MTHI  = 3'b100;
   localparam logic [2:0] MDOP_MTLO  = 3'b101;

   localparam int unsigned DEFAULT_MULT_CYCLES = 5;
   localparam int unsigned DEFAULT_DIV_CYCLES  = 10;

   typedef enum logic {
      StIdle,
      StRun
   } mdu_state_e;

endpackage

// File: rtl/mdu_arith.sv
// Combinational signed/unsigned 32x32 multiply and 32/32 divide.
// Both paths work on operand magnitudes and fix the sign afterwards, which also makes
// 0x80000000 / -1 fall out as quotient 0x80000000, remainder 0.
module mdu_arith
   import mdu_pkg::*;
(
   input  logic [2:0]  op_i,
   input  logic [31:0] a_i,
   input  logic [31:0] b_i,
   output logic [63:0] res_o,
   output logic        div_by_zero_o
);

   logic        signed_op;
   logic        is_div;
   logic        neg_res;
   logic [31:0] mag_a;
   logic [31:0] mag_b;
   logic [31:0] divisor;
   logic [63:0] prod_u;
   logic [31:0] quo_u;
   logic [31:0] rem_u;

   assign signed_op     = (op_i == MDOP_MULT) || (op_i == MDOP_DIV);
   assign is_div        = (op_i == MDOP_DIV) || (op_i == MDOP_DIVU);
   assign div_by_zero_o = is_div && (b_i == 32'd0);

   // Magnitudes, unsigned product/quotient, then sign restoration
   always_comb begin
      mag_a   = (signed_op && a_i[31]) ? -a_i : a_i;
      mag_b   = (signed_op && b_i[31]) ? -b_i : b_i;
      neg_res = signed_op && (a_i[31] ^ b_i[31]);
      // Divisor forced non-zero; a zero-divide result is discarded by the caller
      divisor = (mag_b == 32'd0) ? 32'd1 : mag_b;
      prod_u  = {32'd0, mag_a} * {32'd0, mag_b};
      quo_u   = mag_a / divisor;
      rem_u   = mag_a % divisor;
      if (is_div) begin
         // Remainder follows the sign of the dividend
         res_o = {((signed_op && a_i[31]) ? -rem_u : rem_u), (neg_res ? -quo_u : quo_u)};
      end else begin
         res_o = neg_res ? -prod_u : prod_u;
      end
   end

endmodule

// File: rtl/mdu.sv
// Multi-cycle multiply/divide unit with architectural HI/LO registers.
// The result is computed at launch and parked in pending registers; the busy period only
// models the fixed latency the hazard unit stalls on, after which HI/LO are committed.
module mdu
   import mdu_pkg::*;
#(
   parameter int unsigned MULT_CYCLES = DEFAULT_MULT_CYCLES,
   parameter int unsigned DIV_CYCLES  = DEFAULT_DIV_CYCLES
) (
   input  logic        clk_i,
   input  logic        rst_ni,
   input  logic        start_i,
   input  logic [2:0]  mdop_i,
   input  logic [31:0] md_a_i,
   input  logic [31:0] md_b_i,
   output logic        busy_o,
   output logic [31:0] hi_o,
   output logic [31:0] lo_o
);

   mdu_state_e  state_q, state_d;
   logic [3:0]  cnt_q, cnt_d;
   logic [31:0] pend_hi_q, pend_hi_d;
   logic [31:0] pend_lo_q, pend_lo_d;
   logic        pend_dz_q, pend_dz_d;
   logic [31:0] hi_q, hi_d;
   logic [31:0] lo_q, lo_d;

   logic [63:0] arith_res;
   logic        arith_dz;

   mdu_arith u_arith (
      .op_i          (mdop_i),
      .a_i           (md_a_i),
      .b_i           (md_b_i),
      .res_o         (arith_res),
      .div_by_zero_o (arith_dz)
   );

   // Next-state: launch, mthi/mtlo, countdown and commit
   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      pend_hi_d = pend_hi_q;
      pend_lo_d = pend_lo_q;
      pend_dz_d = pend_dz_q;
      hi_d      = hi_q;
      lo_d      = lo_q;
      case (state_q)
         StIdle: begin
            if (start_i) begin
               if (!mdop_i[2]) begin
                  pend_hi_d = arith_res[63:32];
                  pend_lo_d = arith_res[31:0];
                  pend_dz_d = arith_dz;
                  cnt_d     = mdop_i[1] ? 4'(DIV_CYCLES) : 4'(MULT_CYCLES);
                  state_d   = StRun;
               end else if (mdop_i == MDOP_MTHI) begin
                  hi_d = md_a_i;
               end else if (mdop_i == MDOP_MTLO) begin
                  lo_d = md_a_i;
               end
            end
         end
         StRun: begin
            // Starts here are ignored; the hazard unit is expected to stall them
            if (cnt_q <= 4'd1) begin
               cnt_d   = 4'd0;
               state_d = StIdle;
               if (!pend_dz_q) begin
                  hi_d = pend_hi_q;
                  lo_d = pend_lo_q;
               end
            end else begin
               cnt_d = cnt_q - 4'd1;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   // State registers; reset aborts any in-flight operation
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q   <= StIdle;
         cnt_q     <= 4'd0;
         pend_hi_q <= 32'd0;
         pend_lo_q <= 32'd0;
         pend_dz_q <= 1'b0;
         hi_q      <= 32'd0;
         lo_q      <= 32'd0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         pend_hi_q <= pend_hi_d;
         pend_lo_q <= pend_lo_d;
         pend_dz_q <= pend_dz_d;
         hi_q      <= hi_d;
         lo_q      <= lo_d;
      end
   end

   assign busy_o = (state_q == StRun);
   assign hi_o   = hi_q;
   assign lo_o   = lo_q;

endmodule

// File: doc/mdu.md
Name: mdu

Overview:
- Multi-cycle multiply/divide unit with architectural HI/LO registers.
- Sits in EX beside the single-cycle combinational ALU and takes the same two 32-bit operands.
- Executes mult/multu/div/divu over a fixed latency and raises busy so the hazard unit can stall mfhi/mflo/mult-class instructions.
- Also performs the single-cycle mthi/mtlo writes.

Parameters:
- MULT_CYCLES, 5, busy cycles for mult/multu (legal 1..15).
- DIV_CYCLES, 10, busy cycles for div/divu (legal 1..15).

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- reset  input  1  asynchronous, active-low reset.
- start  input  1  launch request, qualified by mdop; sampled on a rising edge.
- mdop  input  3  operation code:
  - 000 mult, 001 multu, 010 div, 011 divu
  - 100 mthi, 101 mtlo
  - others: no-op
- md_a  input  32  operand A (rs): multiplicand, dividend, or mthi/mtlo source.
- md_b  input  32  operand B (rt): multiplier or divisor.
- busy  output  1  operation in flight.
- hi  output  32  HI register.
- lo  output  32  LO register.

Behaviour:
- Reset (reset=0, asynchronous): hi=0, lo=0, busy=0, counter=0, pending result=0, state IDLE. Reset asserted mid-operation aborts it; the result is discarded and hi/lo return to 0.
- States:
  - IDLE: busy=0.
  - RUN: busy=1.
- Launch: at edge T, a rising edge with state IDLE, start=1 and mdop in 000..011.
  - Compute the 64-bit result from md_a/md_b sampled at T and hold it in internal pending_hi/pending_lo.
  - Load counter with N (MULT_CYCLES or DIV_CYCLES) and go to RUN.
  - busy=1 from T+ for exactly N cycles.
  - On the edge ending the Nth busy cycle: hi/lo take the pending values, state returns to IDLE, busy=0.
  - hi/lo keep their old values throughout RUN.
- mthi/mtlo: in IDLE, start=1 with mdop=100/101 writes md_a into hi/lo at that edge. busy stays 0 and the other register is unchanged.
- start while busy=1 (any mdop): ignored, with no effect on the in-flight operation. The hazard unit must stall and must not issue it.
- mdop 110/111 with start=1: no-op.
- Arithmetic:
  - mult: signed 32x32 to 64; hi=[63:32], lo=[31:0].
  - multu: unsigned 32x32 to 64.
  - div: signed; lo=quotient truncated toward zero; hi=remainder with the sign of the dividend.
  - div with 0x80000000 / 0xFFFFFFFF: lo=0x80000000, hi=0x00000000 (no trap).
  - divu: unsigned quotient/remainder.
- Divide by zero (md_b=0, div or divu): the full busy period of DIV_CYCLES still runs, and at completion hi/lo are left unchanged.
- Back-to-back: start=1 in the first IDLE cycle after completion launches normally, giving one idle cycle between operations.
- The counter never wraps. It is 4 bits wide and decrements only in RUN.

Decomposition:
- Shared package/header: mdop encodings (MDOP_MULT..MDOP_MTLO) and the default latency constants, shared with the controller and hazard unit.
- One sub-module, mdu_arith: combinational signed/unsigned multiply and divide producing the 64-bit {hi,lo} plus a div_by_zero flag.
- mdu itself holds the FSM, counter, pending and HI/LO registers.

Test Plan:
- mult: md_a=0xFFFFFFFF, md_b=2. Expect busy high for exactly 5 cycles, then hi=0xFFFFFFFF, lo=0xFFFFFFFE; hi/lo unchanged while busy.
- multu: same operands. Expect hi=0x00000001, lo=0xFFFFFFFE after 5 busy cycles.
- div: md_a=0xFFFFFFF9 (-7), md_b=2. Expect busy for 10 cycles, then lo=0xFFFFFFFD, hi=0xFFFFFFFF. Also div 0x80000000/0xFFFFFFFF: expect lo=0x80000000, hi=0.
- divu by zero, preceded by mthi 0x12345678 and mtlo 0x9ABCDEF0: mthi/mtlo take effect immediately with busy=0. Then divu 7/0: busy for 10 cycles, hi/lo still 0x12345678/0x9ABCDEF0.
- start with mult 3*4 while a divu is busy: ignored. The divu result commits on schedule, and a later mult 3*4 yields lo=12, hi=0.
- Reset: assert reset=0 asynchronously in the 3rd busy cycle of a mult. Expect busy=0, hi=lo=0 immediately with no clock edge needed; after release the next launch works normally.
